// File: rtl/mem_arbiter.sv
// Three-port arbiter (debug, instruction, data) in front of a single-ported RAM.
// Each access takes three cycles: grant, RAM access, then response.
module mem_arbiter #(
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dbg_req,
  input  logic              i_req,
  input  logic              d_req,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic              dbg_we,
  input  logic              d_we,
  input  logic [DATA_W-1:0] dbg_wdata,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic [1:0]        d_width,
  input  logic              halt,
  output logic              dbg_ack,
  output logic              i_ack,
  output logic              d_ack,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              ram_cs,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic [1:0]        ram_width,
  input  logic [DATA_W-1:0] ram_rdata
);

  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_t;
  typedef enum logic [1:0] {SRC_DBG = 2'd0, SRC_I = 2'd1, SRC_D = 2'd2} src_t;

  state_t state;
  src_t   src;
  logic   last_d;
  logic   grant_dbg;
  logic   grant_i;
  logic   grant_d;

  // Debug always wins; halt only holds back the instruction and data ports.
  always_comb begin
    grant_dbg = 1'b0;
    grant_i   = 1'b0;
    grant_d   = 1'b0;
    if (state == IDLE) begin
      if (dbg_req) begin
        grant_dbg = 1'b1;
      end else if (!halt) begin
        if (i_req && d_req) begin
          grant_d = ~last_d;
          grant_i = last_d;
        end else begin
          grant_i = i_req;
          grant_d = d_req;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      src       <= SRC_DBG;
      last_d    <= 1'b0;
      dbg_ack   <= 1'b0;
      i_ack     <= 1'b0;
      d_ack     <= 1'b0;
      rsp_rdata <= '0;
      ram_cs    <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      ram_width <= 2'd0;
    end else begin
      dbg_ack   <= 1'b0;
      i_ack     <= 1'b0;
      d_ack     <= 1'b0;
      rsp_rdata <= '0;
      case (state)
        IDLE: begin
          if (grant_dbg) begin
            state     <= ACCESS;
            src       <= SRC_DBG;
            ram_cs    <= 1'b1;
            ram_we    <= dbg_we;
            ram_addr  <= dbg_addr;
            ram_wdata <= dbg_wdata;
            ram_width <= 2'd0;
          end else if (grant_i) begin
            state     <= ACCESS;
            src       <= SRC_I;
            last_d    <= 1'b0;
            ram_cs    <= 1'b1;
            ram_we    <= 1'b0;
            ram_addr  <= i_addr;
            ram_wdata <= '0;
            ram_width <= 2'd0;
          end else if (grant_d) begin
            state     <= ACCESS;
            src       <= SRC_D;
            last_d    <= 1'b1;
            ram_cs    <= 1'b1;
            ram_we    <= d_we;
            ram_addr  <= d_addr;
            ram_wdata <= d_wdata;
            ram_width <= d_width;
          end
        end
        ACCESS: begin
          // RAM read data is valid at this edge; capture it with the ack.
          state     <= RESP;
          ram_cs    <= 1'b0;
          ram_we    <= 1'b0;
          ram_addr  <= '0;
          ram_wdata <= '0;
          ram_width <= 2'd0;
          rsp_rdata <= ram_rdata;
          dbg_ack   <= (src == SRC_DBG);
          i_ack     <= (src == SRC_I);
          d_ack     <= (src == SRC_D);
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: requesters, a small RAM, and a cycle-schedule reference
// model that predicts the RAM command and ack for every cycle.
module tb_mem_arbiter;
  localparam int unsigned AW = 64;
  localparam int unsigned DW = 64;

  logic          clk = 1'b0;
  logic          rst, halt;
  logic          dbg_req, i_req, d_req;
  logic [AW-1:0] dbg_addr, i_addr, d_addr;
  logic          dbg_we, d_we;
  logic [DW-1:0] dbg_wdata, d_wdata;
  logic [1:0]    d_width;
  logic          dbg_ack, i_ack, d_ack;
  logic [DW-1:0] rsp_rdata;
  logic          ram_cs, ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [1:0]    ram_width;
  logic [DW-1:0] ram_rdata;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .dbg_req(dbg_req), .i_req(i_req), .d_req(d_req),
    .dbg_addr(dbg_addr), .i_addr(i_addr), .d_addr(d_addr),
    .dbg_we(dbg_we), .d_we(d_we),
    .dbg_wdata(dbg_wdata), .d_wdata(d_wdata), .d_width(d_width),
    .halt(halt),
    .dbg_ack(dbg_ack), .i_ack(i_ack), .d_ack(d_ack),
    .rsp_rdata(rsp_rdata),
    .ram_cs(ram_cs), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_width(ram_width), .ram_rdata(ram_rdata)
  );

  // Port index: 0 = debug, 1 = instruction, 2 = data.
  typedef struct {
    logic        pend;
    logic        granted;
    logic        dropped;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic        we;
    logic [1:0]  width;
    int          ack_cyc;
  } port_t;

  typedef struct {
    logic        cs;
    logic        we;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [1:0]  width;
    logic [2:0]  ack;
    logic [63:0] rdata;
    logic        zero;
  } slot_t;

  port_t       pt [3];
  slot_t       slot [8];
  logic [63:0] ram_mem [16];
  logic [63:0] model_mem [16];
  int          pct [3];
  int          drop_pct;
  int          cyc, free_edge, checks, failures;
  logic        last_d;
  int          ack_log [$];
  int          ack_cycles [$];

  function automatic slot_t blank();
    slot_t s;
    s.cs = 1'b0; s.we = 1'b0; s.addr = '0; s.wdata = '0;
    s.width = 2'd0; s.ack = 3'd0; s.rdata = '0; s.zero = 1'b0;
    return s;
  endfunction

  function automatic logic line(int p);
    return pt[p].pend && !pt[p].dropped;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  task automatic make_req(input int p, input logic [63:0] a, input logic we,
                          input logic [63:0] wd, input logic [1:0] w);
    pt[p].pend = 1'b1; pt[p].granted = 1'b0; pt[p].dropped = 1'b0;
    pt[p].addr = a; pt[p].we = we; pt[p].wdata = wd; pt[p].width = w;
  endtask

  task automatic gen_requests();
    for (int p = 0; p < 3; p++) begin
      if (!pt[p].pend && int'($urandom_range(99)) < pct[p])
        make_req(p, {$urandom, $urandom}, (p == 1) ? 1'b0 : 1'($urandom_range(1)),
                 {$urandom, $urandom}, (p == 2) ? 2'($urandom_range(3)) : 2'd0);
      else if (pt[p].granted && !pt[p].dropped && int'($urandom_range(99)) < drop_pct)
        pt[p].dropped = 1'b1;
    end
  endtask

  // Requesters hold their command until granted, then the fields are don't-care.
  task automatic drive_ports();
    dbg_req   = line(0);
    i_req     = line(1);
    d_req     = line(2);
    dbg_addr  = (pt[0].pend && !pt[0].granted) ? pt[0].addr : {$urandom, $urandom};
    i_addr    = (pt[1].pend && !pt[1].granted) ? pt[1].addr : {$urandom, $urandom};
    d_addr    = (pt[2].pend && !pt[2].granted) ? pt[2].addr : {$urandom, $urandom};
    dbg_we    = (pt[0].pend && !pt[0].granted) ? pt[0].we : 1'($urandom_range(1));
    d_we      = (pt[2].pend && !pt[2].granted) ? pt[2].we : 1'($urandom_range(1));
    dbg_wdata = (pt[0].pend && !pt[0].granted) ? pt[0].wdata : {$urandom, $urandom};
    d_wdata   = (pt[2].pend && !pt[2].granted) ? pt[2].wdata : {$urandom, $urandom};
    d_width   = (pt[2].pend && !pt[2].granted) ? pt[2].width : 2'($urandom_range(3));
  endtask

  // Predict the effect of edge n: schedule the RAM command into cycle n and
  // the ack into cycle n+1; no new grant before edge n+3.
  task automatic model_step(input int n);
    int w;
    logic [63:0] rd;
    if (rst) begin
      slot[n % 8] = blank();
      slot[n % 8].zero = 1'b1;
      slot[(n + 1) % 8] = blank();
      slot[(n + 2) % 8] = blank();
      free_edge = n + 1;
      last_d = 1'b0;
      for (int p = 0; p < 3; p++)
        if (pt[p].granted) begin pt[p].granted = 1'b0; pt[p].dropped = 1'b0; end
    end else if (n >= free_edge) begin
      w = -1;
      if (line(0)) w = 0;
      else if (!halt) begin
        if (line(1) && line(2)) w = last_d ? 1 : 2;
        else if (line(1)) w = 1;
        else if (line(2)) w = 2;
      end
      if (w >= 0) begin
        slot[n % 8].cs    = 1'b1;
        slot[n % 8].we    = pt[w].we;
        slot[n % 8].addr  = pt[w].addr;
        slot[n % 8].wdata = pt[w].wdata;
        slot[n % 8].width = (w == 2) ? pt[w].width : 2'd0;
        rd = model_mem[pt[w].addr[3:0]];
        if (pt[w].we) model_mem[pt[w].addr[3:0]] = pt[w].wdata;
        slot[(n + 1) % 8].ack[w] = 1'b1;
        slot[(n + 1) % 8].rdata  = rd;
        if (w > 0) last_d = (w == 2);
        pt[w].granted = 1'b1;
        pt[w].ack_cyc = n + 1;
        free_edge = n + 3;
      end
    end
  endtask

  task automatic check_cycle(input int n);
    slot_t s;
    s = slot[n % 8];
    chk("ram_cs", 64'(ram_cs), 64'(s.cs));
    chk("acks", 64'({dbg_ack, i_ack, d_ack}), 64'({s.ack[0], s.ack[1], s.ack[2]}));
    chk("rsp_rdata", rsp_rdata, s.rdata);
    if (s.cs || s.zero) begin
      chk("ram_we", 64'(ram_we), 64'(s.we));
      chk("ram_addr", ram_addr, s.addr);
      chk("ram_width", 64'(ram_width), 64'(s.width));
    end
    if ((s.cs && s.we) || s.zero) chk("ram_wdata", ram_wdata, s.zero ? 64'd0 : s.wdata);
    slot[n % 8] = blank();
  endtask

  task automatic tick();
    gen_requests();
    drive_ports();
    model_step(cyc);
    @(posedge clk);
    #1;
    check_cycle(cyc);
    if (dbg_ack) begin ack_log.push_back(0); ack_cycles.push_back(cyc); end
    if (i_ack)   begin ack_log.push_back(1); ack_cycles.push_back(cyc); end
    if (d_ack)   begin ack_log.push_back(2); ack_cycles.push_back(cyc); end
    // RAM: read-before-write, data visible to the arbiter at the next edge.
    if (ram_cs === 1'b1) begin
      ram_rdata = ram_mem[ram_addr[3:0]];
      if (ram_we === 1'b1) ram_mem[ram_addr[3:0]] = ram_wdata;
    end else begin
      ram_rdata = {$urandom, $urandom};
    end
    for (int p = 0; p < 3; p++)
      if (pt[p].granted && pt[p].ack_cyc == cyc) begin
        pt[p].pend = 1'b0; pt[p].granted = 1'b0; pt[p].dropped = 1'b0;
      end
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ack_log.delete();
    ack_cycles.delete();
  endtask

  task automatic chk_order(input string tag, input int exp_seq [4], input int len);
    for (int k = 0; k < len; k++)
      chk($sformatf("%s_order%0d", tag, k),
          64'((k < ack_log.size()) ? ack_log[k] : 99), 64'(exp_seq[k]));
  endtask

  initial begin
    int seq [4];
    int cs_cnt;
    checks = 0; failures = 0; cyc = 0; free_edge = 0; last_d = 1'b0;
    drop_pct = 0;
    for (int p = 0; p < 3; p++) begin
      pct[p] = 0;
      pt[p].pend = 1'b0; pt[p].granted = 1'b0; pt[p].dropped = 1'b0;
      pt[p].addr = '0; pt[p].wdata = '0; pt[p].we = 1'b0; pt[p].width = 2'd0;
      pt[p].ack_cyc = -1;
    end
    for (int k = 0; k < 8; k++) slot[k] = blank();
    for (int k = 0; k < 16; k++) begin
      ram_mem[k] = {$urandom, $urandom};
      model_mem[k] = ram_mem[k];
    end
    halt = 1'b0;
    ram_rdata = '0;
    rst = 1'b1;
    tick();
    do_reset();

    // Single instruction read returning 0xDEAD.
    ram_mem[0] = 64'hDEAD; model_mem[0] = 64'hDEAD;
    make_req(1, 64'h10, 1'b0, 64'h0, 2'd0);
    repeat (5) tick();
    seq = '{1, 0, 0, 0};
    chk_order("iread", seq, 1);

    // Data write of width 2, then read it back through the instruction port.
    make_req(2, 64'h20, 1'b1, 64'h55, 2'd2);
    repeat (5) tick();
    make_req(1, 64'h20, 1'b0, 64'h0, 2'd0);
    repeat (5) tick();

    // Contended I and D from reset: D, I, D, I, one ack every 3 cycles.
    do_reset();
    pct[1] = 100; pct[2] = 100;
    repeat (13) tick();
    seq = '{2, 1, 2, 1};
    chk_order("rr", seq, 4);
    for (int k = 0; k < 3; k++)
      chk($sformatf("rr_gap%0d", k),
          64'((k + 1 < ack_cycles.size()) ? ack_cycles[k + 1] - ack_cycles[k] : 0), 64'd3);
    pct[1] = 0; pct[2] = 0;
    repeat (6) tick();

    // All three request: debug first, I/D rotation unaffected.
    do_reset();
    make_req(0, 64'h3, 1'b0, 64'h0, 2'd0);
    make_req(1, 64'h4, 1'b0, 64'h0, 2'd0);
    make_req(2, 64'h5, 1'b1, 64'h77, 2'd1);
    repeat (10) tick();
    seq = '{0, 2, 1, 0};
    chk_order("dbgfirst", seq, 3);

    // Halt: only a debug read is served; D then I after release.
    do_reset();
    halt = 1'b1;
    make_req(1, 64'h6, 1'b0, 64'h0, 2'd0);
    make_req(2, 64'h7, 1'b0, 64'h0, 2'd3);
    cs_cnt = 0;
    repeat (3) begin tick(); cs_cnt += int'(ram_cs); end
    make_req(0, 64'h8, 1'b0, 64'h0, 2'd0);
    repeat (7) begin tick(); cs_cnt += int'(ram_cs); end
    chk("halt_cs_count", 64'(cs_cnt), 64'd1);
    halt = 1'b0;
    repeat (8) tick();
    seq = '{0, 2, 1, 0};
    chk_order("halt", seq, 3);

    // Reset during ACCESS aborts without ack; held request re-granted right after.
    do_reset();
    make_req(1, 64'h9, 1'b0, 64'h0, 2'd0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (4) tick();
    chk("abort_ack_count", 64'(ack_log.size()), 64'd1);

    // Randomised traffic with drops, halts and occasional resets.
    pct[0] = 8; pct[1] = 35; pct[2] = 35; drop_pct = 30;
    repeat (800) begin
      if ($urandom_range(99) < 6) halt = ~halt;
      rst = ($urandom_range(199) == 0);
      tick();
    end
    rst = 1'b0; halt = 1'b0;
    pct[0] = 0; pct[1] = 0; pct[2] = 0;
    repeat (20) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 64, address width of every port.
REQ-002 SHALL have parameter DATA_W, default 64, data width of every port.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have ports dbg_req/i_req/d_req  input  1 each  access requests: debug, instruction, data.
REQ-006 SHALL have ports dbg_addr/i_addr/d_addr  input  ADDR_W each  request addresses.
REQ-007 SHALL have ports dbg_we/d_we  input  1 each  write enables; the instruction port is read-only.
REQ-008 SHALL have ports dbg_wdata/d_wdata  input  DATA_W each  write data.
REQ-009 SHALL have port d_width  input  2  data write width code, passed through unchanged; debug writes use code 0.
REQ-010 SHALL have port halt  input  1  when high, blocks new instruction and data grants.
REQ-011 SHALL have ports dbg_ack/i_ack/d_ack  output  1 each  one-cycle completion pulses.
REQ-012 SHALL have port rsp_rdata  output  DATA_W  read data, valid only in a cycle where an ack is high.
REQ-013 SHALL have ports ram_cs, ram_we  output  1 each  shared RAM chip select and write enable.
REQ-014 SHALL have ports ram_addr/ram_wdata/ram_width  output  ADDR_W/DATA_W/2  shared RAM command.
REQ-015 SHALL have port ram_rdata  input  DATA_W  RAM read data, valid on the clock edge after a cycle in which ram_cs is high.

Function
REQ-016 SHALL implement FSM states IDLE, ACCESS and RESP, with transitions IDLE->ACCESS on grant, ACCESS->RESP unconditionally, RESP->IDLE unconditionally.
REQ-017 SHALL in IDLE sample requests each edge; priority: dbg_req first; then among i_req/d_req, fixed over the other only if sole requester, else round-robin.
REQ-018 SHALL implement round-robin with a last-granted bit (0=I, 1=D), initialised to 0 (so first contended grant goes to D) and updated only on I/D grants, never on debug grants.
REQ-019 SHALL, while halt=1, grant only dbg_req; i_req/d_req stay pending, no ack.
REQ-020 SHALL register the winner's addr/we/wdata/width at the grant edge; ram_* outputs hold those values throughout ACCESS, ram_cs=1 only in ACCESS.
REQ-021 SHALL drive ram_we=0 for instruction grants, and ram_width=0 for instruction and debug grants.
REQ-022 SHALL in RESP pulse exactly the granted port's ack for one cycle and drive rsp_rdata=ram_rdata; in all other cycles, rsp_rdata=0.
REQ-023 SHALL give a latency of exactly 2 cycles from the grant edge to the ack-high cycle, and a throughput of one access per 3 cycles.
REQ-024 SHALL ignore request changes after the grant; a dropped request still completes and acks (requesters must hold req until ack).
REQ-025 SHALL ignore halt asserted mid-transaction; the transaction in flight completes.
REQ-026 SHALL register the RESP->IDLE transition so that a request still high in RESP is not re-granted until the next IDLE edge.

Reset
REQ-027 SHALL, on rst=1 at an edge: state=IDLE, last-granted=0, all acks=0, ram_cs=0, ram_we=0, ram_addr/ram_wdata/ram_width/rsp_rdata=0.
REQ-028 SHALL abort an in-flight transaction on reset with no ack; rst has priority over all other inputs.

Verification
REQ-029 SHALL cover: i_req, i_addr=0x10, ram_rdata=0xDEAD next cycle -> ram_cs high 1 cycle with addr 0x10, we=0; i_ack 2 cycles after grant with rsp_rdata=0xDEAD.
REQ-030 SHALL cover: d_req write, d_addr=0x20, d_wdata=0x55, d_width=2 -> ram_we=1, ram_width=2, ram_wdata=0x55 for one cycle; d_ack pulses once.
REQ-031 SHALL cover: i_req and d_req held continuously after reset -> grant order D, I, D, I; acks every 3 cycles.
REQ-032 SHALL cover: dbg_req, i_req and d_req all high -> debug served first; subsequent I/D order unaffected by the debug grant.
REQ-033 SHALL cover: halt=1 with i_req/d_req high -> no ram_cs for 10 cycles; dbg_req read served meanwhile; halt=0 -> D then I served.
REQ-034 SHALL cover: rst pulsed during ACCESS -> no ack, all outputs 0 next cycle, and a request held through reset is granted at the first IDLE edge after rst drops.
